// File: rtl/logic_unit_pkg.sv
// Shared constants for the registered bitwise logic unit and its combinational core.
package logic_unit_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOT  = 3'd0;
    localparam op_t OP_AND  = 3'd1;
    localparam op_t OP_OR   = 3'd2;
    localparam op_t OP_XOR  = 3'd3;
    localparam op_t OP_NAND = 3'd4;
    localparam op_t OP_NOR  = 3'd5;
    localparam op_t OP_XNOR = 3'd6;
    localparam op_t OP_PASS = 3'd7;

    localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/logic_op_core.sv
// Purely combinational WIDTH-bit bitwise logic operation selected by a 3-bit op code.
module logic_op_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y
);

    // Every code is defined, so the default only exists to keep the block latch-free.
    always_comb begin
        Y = A;
        case (op)
            OP_NOT:  Y = ~A;
            OP_AND:  Y = A & B;
            OP_OR:   Y = A | B;
            OP_XOR:  Y = A ^ B;
            OP_NAND: Y = ~(A & B);
            OP_NOR:  Y = ~(A | B);
            OP_XNOR: Y = ~(A ^ B);
            OP_PASS: Y = A;
            default: Y = A;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit: results computed on input transfer are queued in a
// two-entry FIFO with valid/ready on both sides, plus a wrapping delivery counter.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

    logic [WIDTH-1:0] core_y;
    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .op (op),
        .A  (A),
        .B  (B),
        .Y  (core_y)
    );

    // Ready is a function of occupancy only, never of out_ready.
    assign in_ready  = (count < DEPTH);
    assign out_valid = (count != 2'd0);
    assign F         = out_valid ? entry0 : '0;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // entry0 is always the head; a pop shifts entry1 forward.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= 2'd0;
            entry0   <= '0;
            entry1   <= '0;
            op_count <= '0;
        end else begin
            if (pop) begin
                op_count <= op_count + CNT_W'(1);
            end
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        entry0 <= core_y;
                    end else begin
                        entry1 <= core_y;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    entry1 <= '0;
                    count  <= count - 2'd1;
                end
                // Only reachable with one entry held: the new result replaces the popped head.
                2'b11: begin
                    entry0 <= core_y;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe; a second CNT_W=3 instance covers counter wrap.
module tb_logic_unit_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [3:0] A;
    logic [3:0] B;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] F;
    logic [7:0] op_count;

    logic       in_ready_w;
    logic       out_valid_w;
    logic [3:0] F_w;
    logic [2:0] op_count_w;

    int vectors;
    int miscompares;

    logic_unit_pipe #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .F         (F),
        .op_count  (op_count)
    );

    logic_unit_pipe #(.WIDTH(4), .CNT_W(3)) dut_wrap (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid_w),
        .out_ready (out_ready),
        .F         (F_w),
        .op_count  (op_count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        op        = 3'd0;
        A         = 4'b0000;
        B         = 4'b0000;
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if (F !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_F: got %b expected 0000", F);
        end
        vectors++;
        if (op_count !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_op_count: got %0d expected 0", op_count);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_nothing_pushed: got out_valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_not;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = 3'd0;
        A         = 4'b0000;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || F !== 4'b1111) begin
            miscompares++;
            $display("[TB] FAIL not_0000: got valid %b F %b expected valid 1 F 1111", out_valid, F);
        end
        A = 4'b0101;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || F !== 4'b1010) begin
            miscompares++;
            $display("[TB] FAIL not_0101: got valid %b F %b expected valid 1 F 1010", out_valid, F);
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (op_count !== 8'd2 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL not_count: got op_count %0d valid %b expected 2 valid 0", op_count, out_valid);
        end
    endtask

    task automatic test_op_table;
        logic [3:0] expected [8];
        expected[0] = 4'b0011;
        expected[1] = 4'b1000;
        expected[2] = 4'b1110;
        expected[3] = 4'b0110;
        expected[4] = 4'b0111;
        expected[5] = 4'b0001;
        expected[6] = 4'b1001;
        expected[7] = 4'b1100;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        A         = 4'b1100;
        B         = 4'b1010;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            tick();
            vectors++;
            if (out_valid !== 1'b1 || F !== expected[i] || in_ready !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL op_table_%0d: got valid %b F %b ready %b expected valid 1 F %b ready 1",
                         i, out_valid, F, in_ready, expected[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (op_count !== 8'd8) begin
            miscompares++;
            $display("[TB] FAIL op_table_count: got %0d expected 8", op_count);
        end
    endtask

    task automatic test_back_pressure;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 3'd3;
        A = 4'b1111; B = 4'b0000;
        tick();
        A = 4'b1010; B = 4'b0011;
        tick();
        A = 4'b0110; B = 4'b0101;
        vectors++;
        if (in_ready !== 1'b0 || F !== 4'b1111) begin
            miscompares++;
            $display("[TB] FAIL bp_full: got ready %b F %b expected ready 0 F 1111", in_ready, F);
        end
        tick();
        tick();
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || F !== 4'b1111) begin
            miscompares++;
            $display("[TB] FAIL bp_hold: got ready %b valid %b F %b expected ready 0 valid 1 F 1111",
                     in_ready, out_valid, F);
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (F !== 4'b1001 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_second: got F %b ready %b expected F 1001 ready 1", F, in_ready);
        end
        tick();
        vectors++;
        if (F !== 4'b0011 || out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_third: got F %b valid %b expected F 0011 valid 1", F, out_valid);
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || op_count !== 8'd3) begin
            miscompares++;
            $display("[TB] FAIL bp_drain: got valid %b op_count %0d expected valid 0 op_count 3",
                     out_valid, op_count);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] a_val;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = 3'd1;
        B         = 4'b0110;
        for (int i = 1; i <= 5; i++) begin
            a_val = 4'(i * 3);
            A = a_val;
            tick();
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || F !== (a_val & 4'b0110)) begin
                miscompares++;
                $display("[TB] FAIL stream_%0d: got valid %b ready %b F %b expected valid 1 ready 1 F %b",
                         i, out_valid, in_ready, F, a_val & 4'b0110);
            end
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (op_count !== 8'd5 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stream_count: got op_count %0d valid %b expected 5 valid 0", op_count, out_valid);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 3'd2;
        A = 4'b0001; B = 4'b0100;
        tick();
        A = 4'b1000; B = 4'b0010;
        tick();
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || F !== 4'b0000 || op_count !== 8'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got valid %b F %b op_count %0d ready %b expected 0 0000 0 1",
                     out_valid, F, op_count, in_ready);
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || op_count !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_discard: got valid %b op_count %0d expected valid 0 op_count 0",
                     out_valid, op_count);
        end
    endtask

    task automatic test_wrap;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = 3'd7;
        for (int i = 1; i <= 9; i++) begin
            A = 4'(i);
            tick();
            vectors++;
            if (op_count_w !== 3'((i - 1) % 8)) begin
                miscompares++;
                $display("[TB] FAIL wrap_step_%0d: got %0d expected %0d", i, op_count_w, (i - 1) % 8);
            end
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (op_count_w !== 3'd1 || op_count !== 8'd9) begin
            miscompares++;
            $display("[TB] FAIL wrap_final: got narrow %0d wide %0d expected narrow 1 wide 9",
                     op_count_w, op_count);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        op          = 3'd0;
        A           = 4'b0000;
        B           = 4'b0000;
        test_reset();
        test_not();
        test_op_table();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
